piso_serializer: RTL
====================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the parallel word width in bits (minimum 2).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 sends din[WIDTH-1] first; 0 sends din[0] first.
REQ-003 The block SHALL have parameter PARITY_EN, default 0: 1 appends one even-parity bit after the data bits.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port din, input, WIDTH bits: the parallel word to serialize.
REQ-007 The block SHALL have port load_valid, input, 1 bit: din is valid and requests transmission.
REQ-008 The block SHALL have port load_ready, output, 1 bit: the block accepts din at this edge.
REQ-009 The block SHALL have port dout, output, WIDTH bits: the current shift-register contents, i.e. the bits not yet sent.
REQ-010 The block SHALL have port out, output, 1 bit: the serial data bit.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out carries a frame bit this cycle.
REQ-012 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse coincident with the first bit of a frame.
REQ-013 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse coincident with the last bit of a frame (the parity bit when PARITY_EN=1).

Function
REQ-014 A word SHALL be accepted on a rising edge where load_valid=1 and load_ready=1; din is captured into the shift register and into a parity register (XOR of din) at that edge.
REQ-015 State machine SHALL have three states: IDLE, SHIFT and PAR.
- IDLE -> SHIFT on accept.
- SHIFT -> PAR after the last data bit when PARITY_EN=1.
- SHIFT or PAR -> IDLE after the last bit with no accept.
- Last bit -> SHIFT directly on accept.
REQ-016 All outputs SHALL be registered; the first bit appears on out in the cycle immediately after the accepting edge (latency 1).
REQ-017 In SHIFT, one data bit SHALL be presented per cycle for exactly WIDTH cycles, in the order set by MSB_FIRST.
REQ-018 dout SHALL shift toward the transmitted end each cycle and zero-fill the vacated end.
REQ-019 A bit counter of width $clog2(WIDTH+1) SHALL track bits sent and SHALL be cleared on each accept.
REQ-020 In PAR, out SHALL equal the XOR of the captured word (even parity) for exactly one cycle.
REQ-021 load_ready SHALL be 1 in IDLE and in the final bit cycle of a frame, and 0 otherwise.
REQ-022 When load_ready=0, load_valid and din SHALL be ignored; a frame in progress is never altered by input changes.
REQ-023 Back-to-back frames SHALL have no gap: an accept in the final bit cycle SHALL put the new word's first bit on out in the next cycle with out_valid held at 1.
REQ-024 In IDLE, out SHALL be 0 and out_valid, frame_start and frame_done SHALL be 0.
REQ-025 When WIDTH=1 data bit remains and PARITY_EN=0, frame_start and frame_done SHALL NOT both be required; with WIDTH>=2, they SHALL never assert in the same cycle.

Reset
REQ-026 While rst=1 at a rising edge, the state SHALL become IDLE, and out, out_valid, frame_start, frame_done, dout, the counter and the parity register SHALL all become 0; load_ready SHALL become 1.
REQ-027 rst SHALL take priority over a simultaneous accept, and a reset mid-frame SHALL abort the frame with no further bits emitted.

Verification
REQ-028 WIDTH=4, MSB_FIRST=1: accept 4'b1011 -> out=1,0,1,1 on cycles 1-4 after accept; frame_start at cycle 1; frame_done at cycle 4; load_ready=0 at cycles 1-3.
REQ-029 MSB_FIRST=0, accept 4'b1011 -> out=1,1,0,1 and dout=0101,0010,0001,0000 on cycles 1-4.
REQ-030 load_valid held at 1 with 4'b1111 then 4'b0001 -> 8 contiguous out_valid cycles with out=1,1,1,1,0,0,0,1 and two frame_start pulses at cycles 1 and 5.
REQ-031 PARITY_EN=1, accept 4'b0111 -> out=0,1,1,1 then parity bit 1; frame_done only on cycle 5; load_ready=1 on cycle 5.
REQ-032 rst=1 after the second bit of 4'b1011 -> next cycle out=0, out_valid=0, dout=0000, load_ready=1; no further bits are emitted.
REQ-033 load_valid=1 with din=4'b0000 during cycle 2 of frame 4'b1011 -> ignored; the remaining bits 1,1 are still sent.

Source files
------------

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in / serial-out shift register with a small framing state machine.
// A word is accepted when load_valid and load_ready are both high at a rising
// edge. Its WIDTH data bits are then presented on `out`, one per cycle. The
// first bit appears in the cycle right after the accepting edge. When
// PARITY_EN is set, one even-parity bit follows the data bits. A new word
// accepted in the final bit cycle of a frame follows with no idle gap.
//
// Parameters
//   WIDTH      parallel word width in bits (>= 2)
//   MSB_FIRST  1: din[WIDTH-1] is sent first, 0: din[0] is sent first
//   PARITY_EN  1: append an even-parity bit after the data bits
//
// Ports
//   clk          single clock, all state changes on its rising edge
//   rst          synchronous active-high reset
//   din          parallel word to serialize
//   load_valid   din is valid and requests transmission
//   load_ready   the block accepts din at this edge (registered)
//   dout         shift-register contents, i.e. the data bits not yet sent
//   out          serial data bit
//   out_valid    out carries a frame bit this cycle
//   frame_start  one-cycle pulse with the first bit of a frame
//   frame_done   one-cycle pulse with the last bit of a frame
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic [WIDTH-1:0] dout,
  output logic             out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             frame_done
);

  localparam int CW = $clog2(WIDTH + 1);

  // Counter value while the last data bit is on `out`.
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;      // index of the data bit currently on `out`
  logic          par_bit;  // even parity of the captured word

  logic accept;
  assign accept = load_valid && load_ready;

  // Bit that leaves the word next: the end that faces the serial output.
  function automatic logic next_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Drops the bit that next_bit() returns and zero-fills the vacated end.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // Every output is a flop. The first bit is loaded straight from din at the
  // accepting edge. The shift register therefore holds only the bits still to
  // come, and dout can be driven directly from it.
  // NOTE: sequential state uses non-blocking assignments only. Each flop
  // then samples the value it had before this edge, whatever the order of
  // the statements below.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      par_bit     <= 1'b0;
      dout        <= '0;
      out         <= 1'b0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      load_ready  <= 1'b1;
    end else if (accept) begin
      // Accept is only possible in IDLE or in a final bit cycle, so this one
      // branch covers both the start from idle and the back-to-back case.
      state       <= SHIFT;
      cnt         <= '0;
      par_bit     <= ^din;
      dout        <= shift_word(din);
      out         <= next_bit(din);
      out_valid   <= 1'b1;
      frame_start <= 1'b1;
      frame_done  <= 1'b0;
      load_ready  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      unique case (state)
        SHIFT: begin
          if (cnt != LAST_IDX) begin
            out  <= next_bit(dout);
            dout <= shift_word(dout);
            cnt  <= cnt + CW'(1);
            // The bit being loaded now closes the frame only if no parity
            // bit follows it.
            if ((cnt + CW'(1)) == LAST_IDX) begin
              frame_done <= !PARITY_EN;
              load_ready <= !PARITY_EN;
            end else begin
              frame_done <= 1'b0;
              load_ready <= 1'b0;
            end
          end else if (PARITY_EN) begin
            state      <= PAR;
            out        <= par_bit;
            frame_done <= 1'b1;
            load_ready <= 1'b1;
          end else begin
            state      <= IDLE;
            cnt        <= '0;
            out        <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            load_ready <= 1'b1;
          end
        end
        PAR: begin
          state      <= IDLE;
          cnt        <= '0;
          out        <= 1'b0;
          out_valid  <= 1'b0;
          frame_done <= 1'b0;
          load_ready <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          out        <= 1'b0;
          out_valid  <= 1'b0;
          frame_done <= 1'b0;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
